// File: rtl/tmds_encoder_if.sv
// rtl/tmds_encoder_if.sv - pixel-side video bus and TMDS symbol outputs
//
// Groups the per-pixel video inputs and the three encoded symbol outputs.
//   de, hsync, vsync : data enable and syncs (lead r/g/b by SYNC_DELAY cycles)
//   r, g, b          : 8-bit colour components
//   tmds_b/g/r       : 10-bit TMDS symbols, channel 0/1/2, bit 0 sent first
// master: pixel source side (drives video, observes symbols)
// slave : encoder side (consumes video, drives symbols)

interface tmds_encoder_if;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] tmds_b;
    logic [9:0] tmds_g;
    logic [9:0] tmds_r;

    modport master (
        output de, hsync, vsync, r, g, b,
        input  tmds_b, tmds_g, tmds_r
    );

    modport slave (
        input  de, hsync, vsync, r, g, b,
        output tmds_b, tmds_g, tmds_r
    );
endinterface

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - DVI/TMDS 8b/10b encoder, three channels, two-stage pipeline
//
// Ports:
//   clk_pix : pixel clock, all state on its rising edge
//   rst_pix : asynchronous active-high reset
//   vid     : tmds_encoder_if.slave (de/hsync/vsync/r/g/b in, tmds_b/g/r out)
// Parameter:
//   SYNC_DELAY : cycles by which de/hsync/vsync are delayed to line up with
//                r/g/b (0..4, 0 = direct wire)
//
// Pipeline: align delay line -> stage A (transition minimisation, aligned
// de and control bits) -> stage B (DC balance or control token, disparity).

module tmds_encoder #(
    parameter int SYNC_DELAY = 1
) (
    input  logic           clk_pix,
    input  logic           rst_pix,
    tmds_encoder_if.slave  vid
);

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] ones8(input logic [7:0] x);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(x[i]);
        end
        return n;
    endfunction

    // Transition minimisation: XNOR chain when the byte is ones-heavy (ties
    // broken on d[0]), XOR chain otherwise. Bit 8 records which chain was used.
    function automatic logic [8:0] min_transitions(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] control_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TOKEN_00;
            2'b01:   t = TOKEN_01;
            2'b10:   t = TOKEN_10;
            default: t = TOKEN_11;
        endcase
        return t;
    endfunction

    // DC balancing. Returns {symbol[9:0], next_cnt[4:0]}. The disparity
    // arithmetic is carried at 6 bits signed so intermediate values such as
    // cnt + 2 + 8 cannot wrap; the result always fits back into 5 bits.
    function automatic logic [14:0] balance(
        input logic [8:0]        q_m,
        input logic signed [4:0] cnt,
        input logic              de,
        input logic [1:0]        c
    );
        logic [3:0]        n1;
        logic signed [5:0] n1s;
        logic signed [5:0] n0s;
        logic signed [5:0] cnt6;
        logic signed [5:0] delta;
        logic signed [5:0] sum6;
        logic [9:0]        sym;
        logic [4:0]        cnt_n;

        n1    = ones8(q_m[7:0]);
        n1s   = {2'b00, n1};
        n0s   = 6'sd8 - n1s;
        cnt6  = {cnt[4], cnt};
        delta = 6'sd0;
        sym   = TOKEN_00;

        if (!de) begin
            sym   = control_token(c);
            cnt_n = 5'd0;
        end else begin
            if ((cnt == 5'sd0) || (n1s == n0s)) begin
                if (q_m[8]) begin
                    sym   = {2'b01, q_m[7:0]};
                    delta = n1s - n0s;
                end else begin
                    sym   = {2'b10, ~q_m[7:0]};
                    delta = n0s - n1s;
                end
            end else if (((cnt6 > 6'sd0) && (n1s > n0s)) ||
                         ((cnt6 < 6'sd0) && (n0s > n1s))) begin
                // Running disparity and this word lean the same way: invert.
                sym   = {1'b1, q_m[8], ~q_m[7:0]};
                delta = (q_m[8] ? 6'sd2 : 6'sd0) + n0s - n1s;
            end else begin
                sym   = {1'b0, q_m[8], q_m[7:0]};
                delta = (q_m[8] ? 6'sd0 : -6'sd2) + n1s - n0s;
            end
            sum6  = cnt6 + delta;
            cnt_n = sum6[4:0];
        end
        return {sym, cnt_n};
    endfunction

    // ------------------------------------------------------------------
    // Align stage: de/syncs delayed to meet the colour data
    // ------------------------------------------------------------------
    logic de_al;
    logic hsync_al;
    logic vsync_al;

    generate
        if ((SYNC_DELAY < 0) || (SYNC_DELAY > 4)) begin : g_bad_delay
            $error("tmds_encoder: SYNC_DELAY must be in 0..4");
        end

        if (SYNC_DELAY == 0) begin : g_no_delay
            assign de_al    = vid.de;
            assign hsync_al = vid.hsync;
            assign vsync_al = vid.vsync;
        end else begin : g_delay
            // Each entry holds {de, vsync, hsync}.
            logic [2:0] dly [SYNC_DELAY];

            always_ff @(posedge clk_pix or posedge rst_pix) begin
                if (rst_pix) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        dly[i] <= 3'b000;
                    end
                end else begin
                    dly[0] <= {vid.de, vid.vsync, vid.hsync};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign {de_al, vsync_al, hsync_al} = dly[SYNC_DELAY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage A: transition minimisation, aligned de and blue control bits
    // ------------------------------------------------------------------
    logic [8:0] qm_b_a;
    logic [8:0] qm_g_a;
    logic [8:0] qm_r_a;
    logic       de_a;
    logic [1:0] ctl_a;      // {c1, c0} = {vsync, hsync}, blue channel only

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            qm_b_a <= 9'd0;
            qm_g_a <= 9'd0;
            qm_r_a <= 9'd0;
            de_a   <= 1'b0;
            ctl_a  <= 2'b00;
        end else begin
            qm_b_a <= min_transitions(vid.b);
            qm_g_a <= min_transitions(vid.g);
            qm_r_a <= min_transitions(vid.r);
            de_a   <= de_al;
            ctl_a  <= {vsync_al, hsync_al};
        end
    end

    // ------------------------------------------------------------------
    // Stage B: DC balancing / control tokens, independent disparity per lane
    // ------------------------------------------------------------------
    logic [9:0]        sym_b;
    logic [9:0]        sym_g;
    logic [9:0]        sym_r;
    logic signed [4:0] cnt_b;
    logic signed [4:0] cnt_g;
    logic signed [4:0] cnt_r;

    logic [9:0]        sym_b_n;
    logic [9:0]        sym_g_n;
    logic [9:0]        sym_r_n;
    logic signed [4:0] cnt_b_n;
    logic signed [4:0] cnt_g_n;
    logic signed [4:0] cnt_r_n;

    always_comb begin
        {sym_b_n, cnt_b_n} = balance(qm_b_a, cnt_b, de_a, ctl_a);
        {sym_g_n, cnt_g_n} = balance(qm_g_a, cnt_g, de_a, 2'b00);
        {sym_r_n, cnt_r_n} = balance(qm_r_a, cnt_r, de_a, 2'b00);
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sym_b <= TOKEN_00;
            sym_g <= TOKEN_00;
            sym_r <= TOKEN_00;
            cnt_b <= 5'sd0;
            cnt_g <= 5'sd0;
            cnt_r <= 5'sd0;
        end else begin
            sym_b <= sym_b_n;
            sym_g <= sym_g_n;
            sym_r <= sym_r_n;
            cnt_b <= cnt_b_n;
            cnt_g <= cnt_g_n;
            cnt_r <= cnt_r_n;
        end
    end

    assign vid.tmds_b = sym_b;
    assign vid.tmds_g = sym_g;
    assign vid.tmds_r = sym_r;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - self-checking bench for tmds_encoder

module tb_tmds_encoder;

    localparam int SD = 1;
    localparam int HN = 16384;

    logic clk_pix = 1'b0;
    logic rst_pix;

    tmds_encoder_if vid ();

    tmds_encoder #(.SYNC_DELAY(SD)) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .vid     (vid)
    );

    always #5 clk_pix = ~clk_pix;

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    // Input history, {de, hsync, vsync, r, g, b}, indexed by the edge that
    // captures it. Entries older than base were flushed by a reset.
    logic [26:0] hist [HN];
    int          base = 0;
    int          m_cnt [3];
    int          rd [3];

    typedef struct {
        logic       de;
        logic       vs;
        logic       hs;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
        logic [9:0] eb;
        logic [9:0] eg;
        logic [9:0] er;
        int         ecb;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    function automatic logic [26:0] hget(input int idx);
        if (idx < base || idx < 0) return 27'd0;
        return hist[idx % HN];
    endfunction

    function automatic int disp(input logic [9:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) if (s[i]) n++;
        return 2 * n - 10;
    endfunction

    task automatic ref_enc(input logic [7:0] d, input logic de, input logic [1:0] c,
                           input int cnt_in, output logic [9:0] sym, output int cnt_out);
        int         nd;
        int         n1;
        int         n0;
        logic       xn;
        logic [8:0] qm;
        nd = 0;
        for (int i = 0; i < 8; i++) if (d[i]) nd++;
        xn    = (nd > 4) || (nd == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) if (qm[i]) n1++;
        n0 = 8 - n1;
        if (!de) begin
            case (c)
                2'b00: sym = 10'h354;
                2'b01: sym = 10'h0AB;
                2'b10: sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            cnt_out = 0;
        end else if (cnt_in == 0 || n1 == n0) begin
            if (qm[8]) begin
                sym = {2'b01, qm[7:0]};
                cnt_out = cnt_in + n1 - n0;
            end else begin
                sym = {2'b10, ~qm[7:0]};
                cnt_out = cnt_in + n0 - n1;
            end
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cnt_out = cnt_in + 2 * int'(qm[8]) + n0 - n1;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cnt_out = cnt_in - 2 * int'(!qm[8]) + n1 - n0;
        end
    endtask

    task automatic model_update();
        logic [26:0] col;
        logic [26:0] ctl;
        logic [9:0]  e [3];
        logic [9:0]  a [3];
        int          nc;
        col = hget(cyc - 1);
        ctl = hget(cyc - 1 - SD);
        ref_enc(col[7:0],   ctl[26], {ctl[24], ctl[25]}, m_cnt[0], e[0], nc); m_cnt[0] = nc;
        ref_enc(col[15:8],  ctl[26], 2'b00,              m_cnt[1], e[1], nc); m_cnt[1] = nc;
        ref_enc(col[23:16], ctl[26], 2'b00,              m_cnt[2], e[2], nc); m_cnt[2] = nc;
        a[0] = vid.tmds_b;
        a[1] = vid.tmds_g;
        a[2] = vid.tmds_r;
        for (int ch = 0; ch < 3; ch++) begin
            check($sformatf("model_sym_ch%0d", ch), int'(a[ch]), int'(e[ch]));
            if (ctl[26]) rd[ch] += disp(a[ch]);
            else rd[ch] = 0;
            check($sformatf("model_disp_ch%0d", ch), rd[ch], m_cnt[ch]);
            check($sformatf("disp_bound_ch%0d", ch), int'(rd[ch] <= 10 && rd[ch] >= -10), 1);
        end
    endtask

    task automatic step(input logic de, input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk_pix);
        vid.de    = de;
        vid.hsync = hs;
        vid.vsync = vs;
        vid.r     = r;
        vid.g     = g;
        vid.b     = b;
        hist[(cyc + 1) % HN] = {de, hs, vs, r, g, b};
        @(posedge clk_pix);
        #1;
        model_update();
    endtask

    task automatic clear_model();
        base = cyc + 1;
        for (int ch = 0; ch < 3; ch++) begin
            m_cnt[ch] = 0;
            rd[ch]    = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 10'h0AB, 10'h354, 10'h354, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 10'h154, 10'h354, 10'h354, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 10'h2AB, 10'h354, 10'h354, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h01, 10'h200, 10'h100, 10'h1FF, -8};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h55, 8'hAA, 10'h1F0, 10'h133, 10'h233, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 8'hAA, 8'h10, 8'h55, 10'h233, 10'h1F0, 10'h133, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h10, 10'h100, 10'h200, 10'h1F0, -8};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h55, 8'hAA, 8'hFF, 10'h133, 10'h233, 10'h200, 0};

        for (int i = 0; i < HN; i++) hist[i] = 27'd0;
        vid.de = 1'b0; vid.hsync = 1'b0; vid.vsync = 1'b0;
        vid.r = 8'h00; vid.g = 8'h00; vid.b = 8'h00;

        // Asynchronous reset before any clock edge.
        rst_pix = 1'b0;
        #1 rst_pix = 1'b1;
        #1;
        check("reset_b", int'(vid.tmds_b), 'h354);
        check("reset_g", int'(vid.tmds_g), 'h354);
        check("reset_r", int'(vid.tmds_r), 'h354);
        @(posedge clk_pix);
        #3 rst_pix = 1'b0;
        clear_model();

        // Idle blanking.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            check("idle_b", int'(vid.tmds_b), 'h354);
            check("idle_r", int'(vid.tmds_r), 'h354);
        end

        // Table: one control or data cycle from a cleared state.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].de, vecs[i].hs, vecs[i].vs, 8'h00, 8'h00, 8'h00);
            step(1'b0, 1'b0, 1'b0, vecs[i].r, vecs[i].g, vecs[i].b);
            check($sformatf("tbl%0d_latency_b", i), int'(vid.tmds_b), 'h354);
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            check($sformatf("tbl%0d_b", i), int'(vid.tmds_b), int'(vecs[i].eb));
            check($sformatf("tbl%0d_g", i), int'(vid.tmds_g), int'(vecs[i].eg));
            check($sformatf("tbl%0d_r", i), int'(vid.tmds_r), int'(vecs[i].er));
            check($sformatf("tbl%0d_disp_b", i), rd[0], vecs[i].ecb);
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            check($sformatf("tbl%0d_after_b", i), int'(vid.tmds_b), 'h354);
            check($sformatf("tbl%0d_after_disp_b", i), rd[0], 0);
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        end

        // Colour 0x00 held: 0x100, 0x3FF, 0x100 with disparity -8, +2, -6.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("zero1_g", int'(vid.tmds_g), 'h100);
        check("zero1_disp_g", rd[1], -8);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("zero2_g", int'(vid.tmds_g), 'h3FF);
        check("zero2_disp_g", rd[1], 2);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("zero3_g", int'(vid.tmds_g), 'h100);
        check("zero3_disp_g", rd[1], -6);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("zero_end_g", int'(vid.tmds_g), 'h354);

        // Random traffic, mostly active with occasional blanking.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Reset asserted between edges in the middle of an active line.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        @(posedge clk_pix);
        #2 rst_pix = 1'b1;
        vid.de = 1'b0; vid.hsync = 1'b0; vid.vsync = 1'b0;
        vid.r = 8'h00; vid.g = 8'h00; vid.b = 8'h00;
        #1;
        check("arst_b", int'(vid.tmds_b), 'h354);
        check("arst_g", int'(vid.tmds_g), 'h354);
        check("arst_r", int'(vid.tmds_r), 'h354);
        @(posedge clk_pix);
        #3 rst_pix = 1'b0;
        clear_model();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("post_rst_token_b", int'(vid.tmds_b), 'h354);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("post_rst_b", int'(vid.tmds_b), 'h100);
        check("post_rst_g", int'(vid.tmds_g), 'h100);
        check("post_rst_r", int'(vid.tmds_r), 'h100);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Pixel-clock DVI/TMDS encoder that consumes the registered 8-bit RGB stream plus the data-enable and sync signals from the pattern/pixel stage. It produces three 10-bit TMDS symbols per pixel clock: blue, green and red. The block sits between pixel generation and the 10:1 serialiser/output primitives. It re-aligns de/syncs to colour, performs 8b/10b transition-minimised, DC-balanced coding, and emits control tokens during blanking.

## Interface
- SYNC_DELAY, default 1: number of clk_pix cycles by which de/hsync/vsync are delayed to align with r/g/b. Legal range 0..4.
- clk_pix  input  1  pixel clock; all logic on its rising edge.
- rst_pix  input  1  reset, asynchronous, active-high.
- de  input  1  data enable; leads r/g/b by SYNC_DELAY cycles.
- hsync  input  1  horizontal sync, same timing as de.
- vsync  input  1  vertical sync, same timing as de.
- r  input  8  red. g  input  8  green. b  input  8  blue.
- tmds_b  output  10  channel 0 symbol, bit 0 transmitted first.
- tmds_g  output  10  channel 1 symbol.
- tmds_r  output  10  channel 2 symbol.

## Operation
- Align stage: de/hsync/vsync pass through a SYNC_DELAY-deep shift register. SYNC_DELAY=0 means a direct wire.
- Stage A is registered, identically per channel. Compute n1 = ones(d).
  - If n1>4, or n1==4 and d[0]==0: use XNOR chain. q_m[0]=d[0], q_m[i]=q_m[i-1] XNOR d[i], q_m[8]=0.
  - Otherwise: use XOR chain with q_m[8]=1.
  - Also register aligned de and control bits {c1,c0}. Blue: {vsync,hsync}. Green and red: 2'b00.
- Stage B is registered and holds a per-channel signed 5-bit disparity cnt. Let N1/N0 = ones/zeros of q_m[7:0].
  - de=1, case 1, cnt==0 or N1==N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? N1−N0 : N0−N1.
  - de=1, case 2, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + N0 − N1.
  - de=1, case 3, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += −2·(~q_m[8]) + N1 − N0.
  - de=0: cnt ← 0. Output control token by {c1,c0}:
    - 00 → 10'b1101010100
    - 01 → 10'b0010101011
    - 10 → 10'b0101010100
    - 11 → 10'b1010101011
- Disparity arithmetic:
  - cnt stays within −10..+10; 5-bit signed never overflows.
  - Intermediate sums are computed at ≥6 bits signed.
- The three channels share control but have independent cnt.
- No state machine beyond cnt and pipeline registers. Mode per cycle is selected by the aligned de.

## Timing
- Colour sampled at edge N appears on tmds_* after edge N+2. Latency is 2 cycles.
- de/syncs sampled at edge N appear after edge N+SYNC_DELAY+2.
- One symbol per clock, no stalls, no handshake. Inputs must be valid every cycle.
- Reset, asynchronously on rst_pix rising, without waiting for a clock:
  - tmds_b/g/r = 10'b1101010100.
  - All cnt = 0.
  - Delay-line and stage A de/hsync/vsync = 0.
  - Stage A q_m = 0.
- First post-reset symbols are control tokens until a de=1 propagates.
- Reset mid-active-line: outputs switch immediately to the reset token and cnt=0. Encoding resumes cleanly from cnt=0 on the next de=1.
- de falling on cycle N:
  - The first control token appears at the stage B output for that cycle's position.
  - cnt clears on the same edge that loads the token.
- de rising: the first data symbol is encoded with cnt=0.

## Test plan
- Reset then idle with de=0, hsync=vsync=0 → tmds_b=tmds_g=tmds_r=0x354 every cycle.
- de=0 with {vsync,hsync} = 01, then 10, then 11 → tmds_b = 0x0AB, then 0x154, then 0x2AB. tmds_g and tmds_r stay 0x354. Each token appears 2+SYNC_DELAY cycles after the sync change.
- SYNC_DELAY=1; de rises, colour 0x00 held on all channels → symbols 0x100, 0x3FF, 0x100, … and cnt sequence −8, +2, −6, …
- From cnt=0, single pixel b=0xFF → tmds_b=0x200 and cnt_b=−8. On the next de=0 cycle → token emitted and cnt_b=0.
- Random colours over 10k active pixels, checked against a reference model of the algorithm above:
  - All symbols match the model.
  - |cnt| ≤ 10 at all times.
  - Running disparity of each channel's emitted bits equals cnt.
- Assert rst_pix asynchronously mid-line, between clock edges → outputs go to 0x354 before the next edge. After release, the first data pixel 0x00 encodes as 0x100.
